// File: rtl/rob_reorder_buf_pkg.sv
// -----------------------------------------------------------------------------
// rob_reorder_buf_pkg
// Shared defaults and types for the reorder buffer and its head timer.
//   ROB_SIZE_DEF / AWIDTH_DEF / DWIDTH_DEF / NRSP_DEF / TIMEOUT_DEF : defaults
//   addr_t      : request address at the default width
//   rob_entry_t : one ROB entry {busy, done, err, addr, data} at default widths
// -----------------------------------------------------------------------------
package rob_reorder_buf_pkg;

  localparam int ROB_SIZE_DEF = 16;
  localparam int AWIDTH_DEF   = 4;
  localparam int DWIDTH_DEF   = 32;
  localparam int NRSP_DEF     = 2;
  localparam int TIMEOUT_DEF  = 200;

  typedef logic [AWIDTH_DEF-1:0] addr_t;

  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic                  err;
    addr_t                 addr;
    logic [DWIDTH_DEF-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_head_timer.sv
// -----------------------------------------------------------------------------
// rob_head_timer
// Counts consecutive cycles the ROB head spends waiting for its response and
// pulses expire on the cycle the wait reaches TIMEOUT cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : head is busy and not yet done
//   clear      : head is retiring this cycle (head pointer changes)
//   expire     : combinational, high in the last permitted waiting cycle
// Only instantiated when ROB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module rob_head_timer
  import rob_reorder_buf_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // cnt_q holds the number of completed waiting cycles; the edge that ends
  // waiting cycle number TIMEOUT is the one that forces the head done.
  assign expire = run && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || !run || expire) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/rob_reorder_buf.sv
// -----------------------------------------------------------------------------
// rob_reorder_buf
// Reorder buffer between one in-order request source and an out-of-order
// memory. Each accepted request gets its ROB slot as tag, up to NRSP tagged
// responses are absorbed per cycle, and results retire strictly in order.
//   req_*        : upstream request handshake and address
//   mem_req_*    : forwarded request (combinational), tag = allocated slot
//   mem_rsp_*    : NRSP response ports, packed per port, always accepted
//   out_*        : in-order result handshake (addr, data, timeout flag)
//   rsp_err      : sticky, set by a stray or duplicate response
//   count        : occupied entries
// Optional feature macro: ROB_TIMEOUT_EN (head-of-line timeout; without it
// out_err is always 0 and entries wait indefinitely).
// -----------------------------------------------------------------------------
module rob_reorder_buf
  import rob_reorder_buf_pkg::*;
#(
  parameter  int ROB_SIZE = ROB_SIZE_DEF,
  parameter  int AWIDTH   = AWIDTH_DEF,
  parameter  int DWIDTH   = DWIDTH_DEF,
  parameter  int NRSP     = NRSP_DEF,
  parameter  int TIMEOUT  = TIMEOUT_DEF,
  localparam int TWIDTH   = $clog2(ROB_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [AWIDTH-1:0]      req_addr,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [AWIDTH-1:0]      mem_req_addr,
  output logic [TWIDTH-1:0]      mem_req_tag,
  input  logic [NRSP-1:0]        mem_rsp_valid,
  input  logic [NRSP*TWIDTH-1:0] mem_rsp_tag,
  input  logic [NRSP*DWIDTH-1:0] mem_rsp_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AWIDTH-1:0]      out_addr,
  output logic [DWIDTH-1:0]      out_data,
  output logic                   out_err,
  output logic                   rsp_err,
  output logic [TWIDTH:0]        count
);

  // Parameter sanity, caught at elaboration.
  if (ROB_SIZE < 2 || (ROB_SIZE & (ROB_SIZE - 1)) != 0) begin : g_bad_rob_size
    $error("rob_reorder_buf: ROB_SIZE must be a power of two >= 2");
  end
  if (NRSP < 1) begin : g_bad_nrsp
    $error("rob_reorder_buf: NRSP must be >= 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("rob_reorder_buf: TIMEOUT must be >= 1");
  end

  typedef struct packed {
    logic              busy;
    logic              done;
    logic              err;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [TWIDTH-1:0]   head_q;
  logic [TWIDTH-1:0]   tail_q;
  logic [TWIDTH:0]     count_q;
  logic [ROB_SIZE-1:0] busy_q;
  logic [ROB_SIZE-1:0] done_q;
  logic [ROB_SIZE-1:0] err_q;
  logic [AWIDTH-1:0]   addr_mem [ROB_SIZE];
  logic [DWIDTH-1:0]   data_mem [ROB_SIZE];
  logic                rsp_err_q;

  // ---------------------------------------------------------------------------
  // Request / retire handshakes
  // ---------------------------------------------------------------------------
  logic   full;
  logic   alloc;
  logic   retire;
  entry_t head_entry;

  // Built from the registered count only: a retire this cycle frees its slot
  // for allocation next cycle, keeping the ready path short.
  assign full = (count_q == (TWIDTH + 1)'(ROB_SIZE));

  // Handshakes are held off while reset is asserted.
  assign mem_req_valid = rst_n && req_valid && !full;
  assign req_ready     = rst_n && mem_req_ready && !full;
  assign mem_req_addr  = req_addr;
  assign mem_req_tag   = tail_q;
  assign alloc         = req_valid && req_ready;

  assign head_entry = {busy_q[head_q], done_q[head_q], err_q[head_q],
                       addr_mem[head_q], data_mem[head_q]};

  assign out_valid = head_entry.busy && head_entry.done;
  assign out_addr  = head_entry.addr;
  assign out_data  = head_entry.data;
  // err_q can only be set by the timeout path, so this is 0 in builds
  // without ROB_TIMEOUT_EN.
  assign out_err   = head_entry.err;
  assign retire    = out_valid && out_ready;

  assign rsp_err = rsp_err_q;
  assign count   = count_q;

  // ---------------------------------------------------------------------------
  // Response acceptance: a port is accepted when its slot is waiting and no
  // lower-indexed port targets the same slot this cycle.
  // ---------------------------------------------------------------------------
  logic [TWIDTH-1:0] rsp_tag  [NRSP];
  logic [DWIDTH-1:0] rsp_data [NRSP];
  logic [NRSP-1:0]   accept;
  logic              stray;
  logic              dup;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it holding its old value and infer a latch.
    accept = '0;
    stray  = 1'b0;
    dup    = 1'b0;
    for (int i = 0; i < NRSP; i++) begin
      rsp_tag[i]  = mem_rsp_tag[i*TWIDTH +: TWIDTH];
      rsp_data[i] = mem_rsp_data[i*DWIDTH +: DWIDTH];
    end
    for (int i = 0; i < NRSP; i++) begin
      dup = 1'b0;
      for (int j = 0; j < i; j++) begin
        if (mem_rsp_valid[j] && (rsp_tag[j] == rsp_tag[i])) dup = 1'b1;
      end
      if (mem_rsp_valid[i]) begin
        if (busy_q[rsp_tag[i]] && !done_q[rsp_tag[i]] && !dup) accept[i] = 1'b1;
        else                                                   stray     = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional head-of-line timeout. A response arriving for the head in the
  // expiry cycle wins, so real data is never overwritten with a timeout.
  // ---------------------------------------------------------------------------
  logic timeout_fire;

`ifdef ROB_TIMEOUT_EN
  logic head_rsp;
  logic expire;

  always_comb begin
    head_rsp = 1'b0;
    for (int i = 0; i < NRSP; i++) begin
      if (accept[i] && (rsp_tag[i] == head_q)) head_rsp = 1'b1;
    end
  end

  rob_head_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_head_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (head_entry.busy && !head_entry.done),
    .clear  (retire),
    .expire (expire)
  );

  assign timeout_fire = expire && !head_rsp;
`else
  assign timeout_fire = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Entry flags. Alloc hits tail and retire hits head; they can only be the
  // same slot when the ROB is empty or full, where one of them is blocked.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      done_q <= '0;
      err_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (retire) busy_q[head_q] <= 1'b0;
      if (alloc) begin
        busy_q[tail_q] <= 1'b1;
        done_q[tail_q] <= 1'b0;
        err_q[tail_q]  <= 1'b0;
      end
      if (timeout_fire) begin
        done_q[head_q] <= 1'b1;
        err_q[head_q]  <= 1'b1;
      end
      for (int i = 0; i < NRSP; i++) begin
        if (accept[i]) done_q[rsp_tag[i]] <= 1'b1;
      end
    end
  end

  // NOTE: the payload arrays are not reset; the busy/done flags qualify every
  // read, so reset only costs routing and blocks RAM inference.
  always_ff @(posedge clk) begin
    if (alloc)        addr_mem[tail_q] <= req_addr;
    if (timeout_fire) data_mem[head_q] <= '0;
    for (int i = 0; i < NRSP; i++) begin
      if (accept[i]) data_mem[rsp_tag[i]] <= rsp_data[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, occupancy and sticky error
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (alloc)  tail_q <= tail_q + 1'b1;
      if (retire) head_q <= head_q + 1'b1;
      case ({alloc, retire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (stray) rsp_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rob_reorder_buf.sv
// -----------------------------------------------------------------------------
// tb_rob_reorder_buf
// Directed bench for rob_reorder_buf at default parameters. Expected results
// are queued when each request is issued and compared when the DUT retires.
// The head-of-line timeout scenario runs only when ROB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_rob_reorder_buf;
  import rob_reorder_buf_pkg::*;

  localparam int ROB_SIZE = 16;
  localparam int AWIDTH   = 4;
  localparam int DWIDTH   = 32;
  localparam int NRSP     = 2;
  localparam int TWIDTH   = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   req_valid;
  logic                   req_ready;
  logic [AWIDTH-1:0]      req_addr;
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic [AWIDTH-1:0]      mem_req_addr;
  logic [TWIDTH-1:0]      mem_req_tag;
  logic [NRSP-1:0]        mem_rsp_valid;
  logic [NRSP*TWIDTH-1:0] mem_rsp_tag;
  logic [NRSP*DWIDTH-1:0] mem_rsp_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [AWIDTH-1:0]      out_addr;
  logic [DWIDTH-1:0]      out_data;
  logic                   out_err;
  logic                   rsp_err;
  logic [TWIDTH:0]        count;

  rob_reorder_buf #(
    .ROB_SIZE (ROB_SIZE),
    .AWIDTH   (AWIDTH),
    .DWIDTH   (DWIDTH),
    .NRSP     (NRSP),
    .TIMEOUT  (200)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_tag   (mem_req_tag),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_tag   (mem_rsp_tag),
    .mem_rsp_data  (mem_rsp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_addr      (out_addr),
    .out_data      (out_data),
    .out_err       (out_err),
    .rsp_err       (rsp_err),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  rob_entry_t        exp_q [$];
  rob_entry_t        mon_e;
  logic [DWIDTH-1:0] plan_data [ROB_SIZE];
  logic [TWIDTH-1:0] tb_tail;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Scoreboard consumer: every retire handshake pops one expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_pending", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_addr", 64'(out_addr), 64'(mon_e.addr));
        check("out_data", 64'(out_data), 64'(mon_e.data));
        check("out_err",  64'(out_err),  64'(mon_e.err));
      end
    end
  end

  // All tasks enter and leave 1 time unit after a rising edge.
  task automatic do_req(input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] d,
                        input logic e);
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clk);
    check("req_ready",    64'(req_ready),    64'd1);
    check("mem_req_tag",  64'(mem_req_tag),  64'(tb_tail));
    check("mem_req_addr", 64'(mem_req_addr), 64'(a));
    plan_data[tb_tail] = d;
    exp_q.push_back('{busy: 1'b1, done: 1'b1, err: e, addr: a, data: d});
    tb_tail = tb_tail + 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic rsp(input int port, input logic [TWIDTH-1:0] t, input logic [DWIDTH-1:0] d);
    mem_rsp_valid[port] = 1'b1;
    mem_rsp_tag[port*TWIDTH +: TWIDTH]  = t;
    mem_rsp_data[port*DWIDTH +: DWIDTH] = d;
    @(posedge clk); #1;
    mem_rsp_valid = '0;
  endtask

  task automatic hold_check(input string name, input logic exp);
    @(negedge clk);
    check(name, 64'(out_valid), 64'(exp));
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    check({name, "_count"}, 64'(count), 64'd0);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    mem_rsp_valid = '0;
    exp_q.delete();
    tb_tail = '0;
    repeat (2) @(negedge clk);
    check("rst_count",     64'(count),     64'd0);
    check("rst_rsp_err",   64'(rsp_err),   64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    req_valid     = 1'b1;
    req_addr      = 4'h9;
    mem_req_ready = 1'b1;
    mem_rsp_valid = '0;
    mem_rsp_tag   = '0;
    mem_rsp_data  = '0;
    out_ready     = 1'b1;
    tb_tail       = '0;

    // Reset: handshakes held low even with a pending request.
    repeat (2) @(negedge clk);
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_req_ready",     64'(req_ready),     64'd0);
    check("rst_out_valid",     64'(out_valid),     64'd0);
    check("rst_count",         64'(count),         64'd0);
    check("rst_rsp_err",       64'(rsp_err),       64'd0);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk); #1;

    // In-order responses.
    for (int i = 0; i < 4; i++) do_req(AWIDTH'(i + 1), DWIDTH'(32'hA0 + i), 1'b0);
    for (int i = 0; i < 4; i++) rsp(0, TWIDTH'(i), plan_data[i]);
    wait_drain("inorder_drain");

    // Reverse-order responses on alternating ports: nothing retires until the
    // head arrives, then four back-to-back retires.
    begin
      logic [TWIDTH-1:0] base;
      base = tb_tail;
      for (int i = 0; i < 4; i++) do_req(AWIDTH'(i + 5), DWIDTH'(32'hB0 + i), 1'b0);
      rsp(1, base + 4'd3, plan_data[base + 4'd3]);
      hold_check("rev_hold3", 1'b0);
      rsp(0, base + 4'd2, plan_data[base + 4'd2]);
      hold_check("rev_hold2", 1'b0);
      rsp(1, base + 4'd1, plan_data[base + 4'd1]);
      hold_check("rev_hold1", 1'b0);
      rsp(0, base, plan_data[base]);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check("rev_burst", 64'(out_valid), 64'd1);
      end
      @(negedge clk);
      check("rev_after_valid", 64'(out_valid), 64'd0);
      check("rev_after_count", 64'(count),     64'd0);
      @(posedge clk); #1;
    end

    // Full ROB, retire, and wrap of the tail pointer.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) do_req(AWIDTH'(i), DWIDTH'(32'hC0 + i), 1'b0);
    req_valid = 1'b1;
    req_addr  = 4'hF;
    @(negedge clk);
    check("full_count",         64'(count),         64'd16);
    check("full_req_ready",     64'(req_ready),     64'd0);
    check("full_mem_req_valid", 64'(mem_req_valid), 64'd0);
    @(posedge clk); #1;
    rsp(0, 4'd0, plan_data[0]);
    out_ready = 1'b1;
    @(negedge clk);
    check("full_head_valid",     64'(out_valid), 64'd1);
    check("full_retire_blocked", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    do_req(4'hF, 32'hD0, 1'b0);
    out_ready = 1'b1;
    for (int t = 1; t < 16; t++) rsp(0, TWIDTH'(t), plan_data[t]);
    rsp(1, 4'd0, plan_data[0]);
    wait_drain("full_drain");

    // Dual response to one slot plus a response landing with an allocation.
    do_reset();
    out_ready = 1'b1;
    do_req(4'h1, 32'h01, 1'b0);
    do_req(4'h2, 32'h02, 1'b0);
    mem_rsp_valid[0]           = 1'b1;
    mem_rsp_tag[0 +: TWIDTH]   = 4'd0;
    mem_rsp_data[0 +: DWIDTH]  = plan_data[0];
    do_req(4'h7, 32'h11, 1'b0);
    mem_rsp_valid = '0;
    rsp(0, 4'd1, plan_data[1]);
    @(negedge clk);
    check("dual_pre_rsp_err", 64'(rsp_err), 64'd0);
    @(posedge clk); #1;
    mem_rsp_valid                  = 2'b11;
    mem_rsp_tag[0 +: TWIDTH]       = 4'd2;
    mem_rsp_tag[TWIDTH +: TWIDTH]  = 4'd2;
    mem_rsp_data[0 +: DWIDTH]      = 32'h11;
    mem_rsp_data[DWIDTH +: DWIDTH] = 32'h22;
    @(posedge clk); #1;
    mem_rsp_valid = '0;
    @(negedge clk);
    check("dual_rsp_err", 64'(rsp_err), 64'd1);
    @(posedge clk); #1;
    wait_drain("dual_drain");

    // Reset with entries in flight, then a stray response into an empty ROB.
    out_ready = 1'b0;
    do_req(4'h3, 32'h33, 1'b0);
    do_req(4'h4, 32'h44, 1'b0);
    do_reset();
    out_ready = 1'b1;
    rsp(0, 4'd5, 32'h55);
    @(negedge clk);
    check("stray_rsp_err",   64'(rsp_err),   64'd1);
    check("stray_out_valid", 64'(out_valid), 64'd0);
    check("stray_count",     64'(count),     64'd0);
    @(posedge clk); #1;

`ifdef ROB_TIMEOUT_EN
    // Head-of-line timeout: forced retire with data 0 and err, then a late
    // response for the retired tag is stray.
    begin
      int n;
      do_reset();
      out_ready = 1'b1;
      do_req(4'h3, 32'h0, 1'b1);
      n = 0;
      while (!out_valid && n < 400) begin
        @(posedge clk); #1;
        n++;
      end
      check("timeout_latency_ok", 64'(n >= 199 && n <= 201), 64'd1);
      repeat (250 - n) begin
        @(posedge clk); #1;
      end
      check("timeout_drained", 64'(exp_q.size()), 64'd0);
      check("timeout_pre_err", 64'(rsp_err),      64'd0);
      rsp(0, 4'd0, 32'hEE);
      @(negedge clk);
      check("timeout_late_rsp_err", 64'(rsp_err),   64'd1);
      check("timeout_out_valid",    64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
